// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bus arbiter: FSM states,
// requester identifiers and the captured access record.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;
  // Wide enough for the largest legal read latency (4).
  localparam int LAT_W      = 3;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/reg_arb_slot.sv
// One-entry pending buffer for a requester that cannot stall. A new strobe is
// accepted when the slot is empty or is being handed to the FSM in the same cycle.
module reg_arb_slot
  import reg_arb_pkg::*;
#(
  parameter type slot_t = req_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  slot_t i_req,
  input  logic  i_take,
  input  logic  i_ovf_clr,
  output logic  o_valid,
  output slot_t o_req,
  output logic  o_ovf
);

  logic  r_valid;
  slot_t r_req;
  logic  r_ovf;
  logic  w_accept;

  assign w_accept = i_load && (!r_valid || i_take);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_req   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_req   <= i_req;
      end else if (i_take) begin
        r_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (i_load && !w_accept) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_req   = r_req;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-file port between the I2C (A) and SPI (B) requesters,
// sequencing registered write/read strobes and returning read data with a done pulse.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [1:0]        ovf,
  input  logic              ovf_clr,
  output logic              busy,
  output arb_state_t        dbg_state
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_t;

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_rr_ptr;
  logic             r_owner;
  logic             r_cur_we;
  logic [LAT_W-1:0] r_wait_cnt;

  logic    w_a_valid, w_b_valid;
  logic    w_a_ovf, w_b_ovf;
  access_t w_a_slot, w_b_slot;
  access_t w_win;
  logic    w_grant, w_grant_sel, w_tie;
  logic    w_take_a, w_take_b;

  reg_arb_slot #(.slot_t(access_t)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (a_req),
    .i_req     ({a_we, a_addr, a_wdata}),
    .i_take    (w_take_a),
    .i_ovf_clr (ovf_clr),
    .o_valid   (w_a_valid),
    .o_req     (w_a_slot),
    .o_ovf     (w_a_ovf)
  );

  reg_arb_slot #(.slot_t(access_t)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (b_req),
    .i_req     ({b_we, b_addr, b_wdata}),
    .i_take    (w_take_b),
    .i_ovf_clr (ovf_clr),
    .o_valid   (w_b_valid),
    .o_req     (w_b_slot),
    .o_ovf     (w_b_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_sel = REQ_A;
    w_tie       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_a_valid || w_b_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
          if (w_a_valid && w_b_valid) begin
            w_tie       = 1'b1;
            w_grant_sel = (FIXED_PRIO != 0) ? REQ_A : r_rr_ptr;
          end else begin
            w_grant_sel = w_b_valid ? REQ_B : REQ_A;
          end
        end
      end
      ISSUE:   w_state_nxt = r_cur_we ? DONE : WAIT;
      WAIT:    if (r_wait_cnt == LAT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_take_a = w_grant && (w_grant_sel == REQ_A);
  assign w_take_b = w_grant && (w_grant_sel == REQ_B);
  assign w_win    = (w_grant_sel == REQ_B) ? w_b_slot : w_a_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= REQ_A;
      r_owner    <= REQ_A;
      r_cur_we   <= 1'b0;
      r_wait_cnt <= '0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      // Strobes are launched on the grant edge so they are registered during ISSUE.
      if (w_grant) begin
        r_owner   <= w_grant_sel;
        r_cur_we  <= w_win.we;
        reg_addr  <= w_win.addr;
        reg_wdata <= w_win.wdata;
        reg_wr    <= w_win.we;
        reg_rd    <= !w_win.we;
        if (w_tie) r_rr_ptr <= !w_grant_sel;
      end
      if (r_state == ISSUE) begin
        r_wait_cnt <= LAT_W'(1);
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + LAT_W'(1);
      end
      if (r_state == WAIT && w_state_nxt == DONE) begin
        if (r_owner == REQ_A) a_rdata <= reg_rdata;
        else                  b_rdata <= reg_rdata;
      end
      a_done <= (w_state_nxt == DONE) && (r_owner == REQ_A);
      b_done <= (w_state_nxt == DONE) && (r_owner == REQ_B);
    end
  end

  assign ovf       = {w_b_ovf, w_a_ovf};
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: two instances (latency 1 / round-robin and latency 4 /
// fixed priority) share stimulus and are each checked against a transaction-level model.
module tb_reg_bus_arbiter;
  import reg_arb_pkg::*;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic       x;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rfd;
    int         done0;
    int         done1;
    logic [7:0] rdata;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_req, a_we, b_req, b_we, ovf_clr;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

  logic [1:0]      t_a_done, t_b_done, t_reg_wr, t_reg_rd, t_busy;
  logic [1:0][7:0] t_a_rdata, t_b_rdata, t_reg_addr, t_reg_wdata, rf;
  logic [1:0][1:0] t_ovf;
  arb_state_t      t_st0, t_st1;
  logic            rf_hold;
  logic [7:0]      rf_val;

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(t_a_done[0]), .a_rdata(t_a_rdata[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(t_b_done[0]), .b_rdata(t_b_rdata[0]),
    .reg_addr(t_reg_addr[0]), .reg_wdata(t_reg_wdata[0]),
    .reg_wr(t_reg_wr[0]), .reg_rd(t_reg_rd[0]), .reg_rdata(rf[0]),
    .ovf(t_ovf[0]), .ovf_clr(ovf_clr), .busy(t_busy[0]), .dbg_state(t_st0)
  );

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(4), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(t_a_done[1]), .a_rdata(t_a_rdata[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(t_b_done[1]), .b_rdata(t_b_rdata[1]),
    .reg_addr(t_reg_addr[1]), .reg_wdata(t_reg_wdata[1]),
    .reg_wr(t_reg_wr[1]), .reg_rd(t_reg_rd[1]), .reg_rdata(rf[1]),
    .ovf(t_ovf[1]), .ovf_clr(ovf_clr), .busy(t_busy[1]), .dbg_state(t_st1)
  );

  int n_cmp;
  int n_bad;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int fp_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slots, one access in flight measured by its age
  // (1 = strobe cycle, len = done cycle), and the expected registered outputs.
  logic       m_sv   [2][2];
  acc_t       m_slot [2][2];
  logic [1:0] m_ovf  [2];
  int         m_rr   [2];
  logic       m_act  [2];
  int         m_who  [2];
  acc_t       m_cur  [2];
  int         m_age  [2];
  int         m_len  [2];
  logic       e_wr   [2];
  logic       e_rd   [2];
  logic       e_done [2][2];
  logic [7:0] e_addr [2];
  logic [7:0] e_wdata[2];
  logic [7:0] e_rdata[2][2];

  task automatic model_reset(input int d);
    for (int x = 0; x < 2; x++) begin
      m_sv[d][x]    = 1'b0;
      m_slot[d][x]  = '0;
      e_done[d][x]  = 1'b0;
      e_rdata[d][x] = 8'h00;
    end
    m_ovf[d] = 2'b00; m_rr[d] = 0; m_act[d] = 1'b0; m_who[d] = 0;
    m_cur[d] = '0; m_age[d] = 0; m_len[d] = 0;
    e_wr[d] = 1'b0; e_rd[d] = 1'b0; e_addr[d] = 8'h00; e_wdata[d] = 8'h00;
  endtask

  task automatic model_update();
    logic rq[2];
    acc_t inp[2];
    int   w;
    rq[0] = a_req; rq[1] = b_req;
    inp[0] = {a_we, a_addr, a_wdata};
    inp[1] = {b_we, b_addr, b_wdata};
    for (int d = 0; d < 2; d++) begin
      w = -1;
      if (!rst_n) begin
        model_reset(d);
      end else begin
        e_wr[d] = 1'b0; e_rd[d] = 1'b0;
        e_done[d][0] = 1'b0; e_done[d][1] = 1'b0;
        if (m_act[d]) begin
          if (!m_cur[d].we && m_age[d] == m_len[d] - 1) e_rdata[d][m_who[d]] = rf[d];
          if (m_age[d] == m_len[d]) begin
            m_act[d] = 1'b0;
          end else begin
            m_age[d]++;
            if (m_age[d] == m_len[d]) e_done[d][m_who[d]] = 1'b1;
          end
        end else if (m_sv[d][0] || m_sv[d][1]) begin
          if (m_sv[d][0] && m_sv[d][1]) begin
            w = (fp_of(d) != 0) ? 0 : m_rr[d];
            m_rr[d] = 1 - w;
          end else begin
            w = m_sv[d][1] ? 1 : 0;
          end
          m_act[d] = 1'b1; m_who[d] = w; m_cur[d] = m_slot[d][w]; m_age[d] = 1;
          m_len[d] = m_cur[d].we ? 2 : 2 + lat_of(d);
          e_wr[d] = m_cur[d].we; e_rd[d] = !m_cur[d].we;
          e_addr[d] = m_cur[d].addr; e_wdata[d] = m_cur[d].wdata;
        end
        if (ovf_clr) m_ovf[d] = 2'b00;
        for (int x = 0; x < 2; x++) begin
          if (rq[x]) begin
            if (!m_sv[d][x] || w == x) begin
              m_slot[d][x] = inp[x];
              m_sv[d][x]   = 1'b1;
            end else begin
              m_ovf[d][x] = 1'b1;
            end
          end else if (w == x) begin
            m_sv[d][x] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_busy", d),      32'(t_busy[d]),      32'(m_act[d]));
      check($sformatf("d%0d_reg_wr", d),    32'(t_reg_wr[d]),    32'(e_wr[d]));
      check($sformatf("d%0d_reg_rd", d),    32'(t_reg_rd[d]),    32'(e_rd[d]));
      check($sformatf("d%0d_reg_addr", d),  32'(t_reg_addr[d]),  32'(e_addr[d]));
      check($sformatf("d%0d_reg_wdata", d), 32'(t_reg_wdata[d]), 32'(e_wdata[d]));
      check($sformatf("d%0d_a_done", d),    32'(t_a_done[d]),    32'(e_done[d][0]));
      check($sformatf("d%0d_b_done", d),    32'(t_b_done[d]),    32'(e_done[d][1]));
      check($sformatf("d%0d_a_rdata", d),   32'(t_a_rdata[d]),   32'(e_rdata[d][0]));
      check($sformatf("d%0d_b_rdata", d),   32'(t_b_rdata[d]),   32'(e_rdata[d][1]));
      check($sformatf("d%0d_ovf", d),       32'(t_ovf[d]),       32'(m_ovf[d]));
      check($sformatf("d%0d_wr_rd_excl", d),   32'(t_reg_wr[d] & t_reg_rd[d]), 32'd0);
      check($sformatf("d%0d_done_excl", d),    32'(t_a_done[d] & t_b_done[d]), 32'd0);
    end
  endtask

  // One clock: model and DUT see the same stable inputs at the edge,
  // register-file data changes just after it, outputs are compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    for (int d = 0; d < 2; d++) rf[d] = rf_hold ? rf_val : 8'($urandom);
    #2;
    compare_all();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle_inputs();
    a_req = 1'b0; b_req = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic drive_req(input logic x, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
    if (x == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
  endtask

  task automatic wait_idle();
    int i;
    logic idle;
    i = 0;
    idle = 1'b0;
    while (i < 40 && !idle) begin
      tick();
      idle = (t_busy == 2'b00) && !m_sv[0][0] && !m_sv[0][1] && !m_sv[1][0] && !m_sv[1][1];
      i++;
    end
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic tie_round(input int exp_first0, input int exp_first1, input string tag);
    int cnt[2], first[2], second[2];
    wait_idle();
    drive_req(1'b0, 1'b1, 8'h31, 8'hC1);
    drive_req(1'b1, 1'b1, 8'h32, 8'hC2);
    for (int d = 0; d < 2; d++) begin cnt[d] = 0; first[d] = -1; second[d] = -1; end
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) idle_inputs();
      for (int d = 0; d < 2; d++) begin
        for (int x = 0; x < 2; x++) begin
          if ((x == 0) ? t_a_done[d] : t_b_done[d]) begin
            if (cnt[d] == 0) first[d] = x;
            else if (cnt[d] == 1) second[d] = x;
            cnt[d]++;
          end
        end
      end
    end
    check($sformatf("%s_d0_count", tag), 32'(cnt[0]), 32'd2);
    check($sformatf("%s_d0_first", tag), 32'(first[0]), 32'(exp_first0));
    check($sformatf("%s_d0_second", tag), 32'(second[0]), 32'(1 - exp_first0));
    check($sformatf("%s_d1_count", tag), 32'(cnt[1]), 32'd2);
    check($sformatf("%s_d1_first", tag), 32'(first[1]), 32'(exp_first1));
    check($sformatf("%s_d1_second", tag), 32'(second[1]), 32'(1 - exp_first1));
  endtask

  vec_t vecs[6];

  initial begin
    int s_at[2], d_at[2], oth[2], dn;
    logic [7:0] s_addr[2], s_wdata[2], rd_v[2];
    logic s_wr[2];

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    rf = '0; rf_hold = 1'b0; rf_val = 8'h00;

    vecs[0] = '{x:1'b0, we:1'b1, addr:8'h01, wdata:8'hA5, rfd:8'h00, done0:3, done1:3, rdata:8'h00};
    vecs[1] = '{x:1'b1, we:1'b0, addr:8'h02, wdata:8'h00, rfd:8'h3C, done0:4, done1:7, rdata:8'h3C};
    vecs[2] = '{x:1'b0, we:1'b0, addr:8'h10, wdata:8'h00, rfd:8'h5A, done0:4, done1:7, rdata:8'h5A};
    vecs[3] = '{x:1'b1, we:1'b1, addr:8'hFF, wdata:8'h00, rfd:8'h00, done0:3, done1:3, rdata:8'h00};
    vecs[4] = '{x:1'b0, we:1'b0, addr:8'h00, wdata:8'h00, rfd:8'hFF, done0:4, done1:7, rdata:8'hFF};
    vecs[5] = '{x:1'b1, we:1'b1, addr:8'h80, wdata:8'h7E, rfd:8'h00, done0:3, done1:3, rdata:8'h00};

    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single accesses into an idle arbiter.
    foreach (vecs[i]) begin
      wait_idle();
      rf_hold = 1'b1; rf_val = vecs[i].rfd;
      drive_req(vecs[i].x, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      for (int d = 0; d < 2; d++) begin
        s_at[d] = -1; d_at[d] = -1; oth[d] = 0;
        s_addr[d] = 8'h00; s_wdata[d] = 8'h00; rd_v[d] = 8'h00; s_wr[d] = 1'b0;
      end
      for (int k = 1; k <= 12; k++) begin
        tick();
        if (k == 1) idle_inputs();
        for (int d = 0; d < 2; d++) begin
          if ((t_reg_wr[d] || t_reg_rd[d]) && s_at[d] < 0) begin
            s_at[d] = k; s_addr[d] = t_reg_addr[d]; s_wdata[d] = t_reg_wdata[d]; s_wr[d] = t_reg_wr[d];
          end
          if ((vecs[i].x ? t_b_done[d] : t_a_done[d]) && d_at[d] < 0) begin
            d_at[d] = k; rd_v[d] = vecs[i].x ? t_b_rdata[d] : t_a_rdata[d];
          end
          if (vecs[i].x ? t_a_done[d] : t_b_done[d]) oth[d]++;
        end
      end
      for (int d = 0; d < 2; d++) begin
        check($sformatf("v%0d_d%0d_strobe_at", i, d), 32'(s_at[d]), 32'd2);
        check($sformatf("v%0d_d%0d_strobe_kind", i, d), 32'(s_wr[d]), 32'(vecs[i].we));
        check($sformatf("v%0d_d%0d_addr", i, d), 32'(s_addr[d]), 32'(vecs[i].addr));
        check($sformatf("v%0d_d%0d_wdata", i, d), 32'(s_wdata[d]), 32'(vecs[i].wdata));
        check($sformatf("v%0d_d%0d_done_at", i, d), 32'(d_at[d]),
              32'((d == 0) ? vecs[i].done0 : vecs[i].done1));
        check($sformatf("v%0d_d%0d_other_done", i, d), 32'(oth[d]), 32'd0);
        if (!vecs[i].we)
          check($sformatf("v%0d_d%0d_rdata", i, d), 32'(rd_v[d]), 32'(vecs[i].rdata));
      end
      rf_hold = 1'b0;
    end

    // Simultaneous requests: round-robin alternates, fixed priority keeps A first.
    tie_round(0, 0, "tie1");
    tie_round(1, 0, "tie2");

    // Overflow: A strobes while B's read is in progress.
    wait_idle();
    drive_req(1'b1, 1'b0, 8'h44, 8'h00);
    tick(); idle_inputs();
    tick();
    drive_req(1'b0, 1'b1, 8'h55, 8'h11);
    tick();
    drive_req(1'b0, 1'b1, 8'h56, 8'h22);
    tick();
    check("ovf_after_drop_d0", 32'(t_ovf[0]), 32'd1);
    check("ovf_after_drop_d1", 32'(t_ovf[1]), 32'd1);
    drive_req(1'b0, 1'b1, 8'h57, 8'h33);
    ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("ovf_set_wins_d0", 32'(t_ovf[0]), 32'd1);
    check("ovf_set_wins_d1", 32'(t_ovf[1]), 32'd1);
    wait_idle();
    ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("ovf_cleared_d0", 32'(t_ovf[0]), 32'd0);
    check("ovf_cleared_d1", 32'(t_ovf[1]), 32'd0);

    // Reset during a read's WAIT phase.
    wait_idle();
    drive_req(1'b1, 1'b0, 8'h66, 8'h00);
    tick(); idle_inputs();
    tick(); tick();
    check("pre_reset_state_d0", 32'(t_st0), 32'(WAIT));
    check("pre_reset_state_d1", 32'(t_st1), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_d%0d_busy", d), 32'(t_busy[d]), 32'd0);
      check($sformatf("rst_d%0d_rd", d), 32'(t_reg_rd[d]), 32'd0);
      check($sformatf("rst_d%0d_addr", d), 32'(t_reg_addr[d]), 32'd0);
      check($sformatf("rst_d%0d_done", d), 32'({t_a_done[d], t_b_done[d]}), 32'd0);
      check($sformatf("rst_d%0d_rdata", d), 32'({t_a_rdata[d], t_b_rdata[d]}), 32'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      dn += int'(t_a_done[0]) + int'(t_b_done[0]) + int'(t_a_done[1]) + int'(t_b_done[1]);
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    drive_req(1'b0, 1'b1, 8'h77, 8'h99);
    for (int d = 0; d < 2; d++) d_at[d] = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) idle_inputs();
      for (int d = 0; d < 2; d++) if (t_a_done[d] && d_at[d] < 0) d_at[d] = k;
    end
    check("post_reset_done_d0", 32'(d_at[0]), 32'd3);
    check("post_reset_done_d1", 32'(d_at[1]), 32'd3);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      a_req = ($urandom_range(0, 3) == 0);
      a_we = 1'($urandom); a_addr = 8'($urandom); a_wdata = 8'($urandom);
      b_req = ($urandom_range(0, 3) == 0);
      b_we = 1'($urandom); b_addr = 8'($urandom); b_wdata = 8'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
